// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared widths and vector types for the array multiplier
package mult_pkg;

  localparam int DEFAULT_WIDTH = 2;

  // Full product width for a given operand width; the product never overflows it.
  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  localparam int DEFAULT_PROD_WIDTH = prod_width(DEFAULT_WIDTH);

  typedef logic [DEFAULT_WIDTH-1:0]      operand_t;
  typedef logic [DEFAULT_PROD_WIDTH-1:0] product_t;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - one-bit full adder cell of the reduction array
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  // Plain sum/majority; tying cin low turns this into a half adder.
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier_2bit.sv
// rtl/multiplier_2bit.sv - unsigned ripple-carry array multiplier with registered product
module multiplier_2bit
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   P
);

  localparam int PW = prod_width(WIDTH);

  // pp[i] is A gated by multiplier bit i, weighted by 2^i.
  logic [WIDTH-1:0] pp [WIDTH];

  // Row k takes the running sum (already shifted right by one) and adds pp[k].
  // Carries are kept as separate bits so the ripple chain is not a self-loop
  // through one packed vector.
  logic [WIDTH-1:0] row_in  [1:WIDTH-1];
  logic [WIDTH-1:0] row_sum [1:WIDTH-1];
  logic             row_cy  [1:WIDTH-1][WIDTH+1];

  logic [PW-1:0] prod_comb;

  genvar i, j, k;

  // Partial-product AND plane.
  generate
    for (i = 0; i < WIDTH; i++) begin : g_pp_row
      for (j = 0; j < WIDTH; j++) begin : g_pp_bit
        assign pp[i][j] = A[j] & B[i];
      end
    end
  endgenerate

  // Bit 0 of the product is settled by pp[0] alone; its upper bits seed row 1.
  assign prod_comb[0] = pp[0][0];
  assign row_in[1]    = {1'b0, pp[0][WIDTH-1:1]};

  // Adder array: each row retires one product bit and passes the rest down.
  generate
    for (k = 1; k < WIDTH; k++) begin : g_row
      assign row_cy[k][0] = 1'b0;
      for (j = 0; j < WIDTH; j++) begin : g_cell
        full_adder u_fa (
          .a    (pp[k][j]),
          .b    (row_in[k][j]),
          .cin  (row_cy[k][j]),
          .sum  (row_sum[k][j]),
          .cout (row_cy[k][j+1])
        );
      end
      assign prod_comb[k] = row_sum[k][0];
      if (k < WIDTH - 1) begin : g_pass
        assign row_in[k+1] = {row_cy[k][WIDTH], row_sum[k][WIDTH-1:1]};
      end else begin : g_last
        // The last row's carry-out is the product MSB.
        assign prod_comb[PW-1:WIDTH] = {row_cy[k][WIDTH], row_sum[k][WIDTH-1:1]};
      end
    end
  endgenerate

  // Product register; reset wins over the freshly computed product.
  always_ff @(posedge clk) begin
    if (rst) begin
      P <= '0;
    end else begin
      P <= prod_comb;
    end
  end

endmodule

// File: tb/tb_multiplier_2bit.sv
// tb/tb_multiplier_2bit.sv - scoreboard bench for the 2-bit and 8-bit multiplier builds
module tb_multiplier_2bit;

  typedef struct {
    logic [15:0] p;
    string       tag;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a2, b2;
  logic [3:0] p2;
  logic       rst8;
  logic [7:0] a8, b8;
  logic [15:0] p8;

  exp_t q2[$];
  exp_t q8[$];

  int  checks = 0;
  int  errors = 0;
  bit  done2 = 1'b0;
  bit  done8 = 1'b0;

  always #5 clk = ~clk;

  multiplier_2bit #(.WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .A   (a2),
    .B   (b2),
    .P   (p2)
  );

  multiplier_2bit #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .A   (a8),
    .B   (b8),
    .P   (p8)
  );

  // Drive one WIDTH=2 vector before the edge and queue what P must show after it.
  task automatic step2(input logic [1:0] a, input logic [1:0] b, input logic r,
                       input logic [3:0] exp_p, input string tag);
    exp_t e;
    @(negedge clk);
    a2 = a;
    b2 = b;
    rst = r;
    e.p = {12'd0, exp_p};
    e.tag = tag;
    q2.push_back(e);
  endtask

  task automatic step8(input logic [7:0] a, input logic [7:0] b, input logic r,
                       input logic [15:0] exp_p, input string tag);
    exp_t e;
    @(negedge clk);
    a8 = a;
    b8 = b;
    rst8 = r;
    e.p = exp_p;
    e.tag = tag;
    q8.push_back(e);
  endtask

  // WIDTH=2 stimulus: hand-computed directed vectors, then all 16 pairs.
  initial begin
    rst = 1'b1;
    a2 = 2'd0;
    b2 = 2'd0;
    step2(2'd3, 2'd3, 1'b1, 4'd0, "reset_hold1");
    step2(2'd3, 2'd3, 1'b1, 4'd0, "reset_hold2");
    step2(2'd3, 2'd3, 1'b0, 4'd9, "reset_release");
    step2(2'd1, 2'd2, 1'b0, 4'd2, "d_1x2");
    step2(2'd1, 2'd3, 1'b0, 4'd3, "d_1x3");
    step2(2'd1, 2'd1, 1'b0, 4'd1, "d_1x1");
    step2(2'd2, 2'd3, 1'b0, 4'd6, "d_2x3");
    step2(2'd3, 2'd1, 1'b0, 4'd3, "d_3x1");
    step2(2'd2, 2'd2, 1'b0, 4'd4, "d_2x2");
    step2(2'd2, 2'd1, 1'b0, 4'd2, "d_2x1");
    step2(2'd0, 2'd3, 1'b0, 4'd0, "z_0x3");
    step2(2'd3, 2'd0, 1'b0, 4'd0, "z_3x0");
    step2(2'd0, 2'd0, 1'b0, 4'd0, "z_0x0");
    step2(2'd1, 2'd3, 1'b0, 4'd3, "comm_1x3");
    step2(2'd3, 2'd1, 1'b0, 4'd3, "comm_3x1");
    step2(2'd3, 2'd3, 1'b0, 4'd9, "b2b_3x3");
    step2(2'd2, 2'd3, 1'b0, 4'd6, "b2b_2x3");
    step2(2'd1, 2'd2, 1'b0, 4'd2, "b2b_1x2");
    step2(2'd2, 2'd2, 1'b0, 4'd4, "b2b_2x2");
    step2(2'd2, 2'd3, 1'b0, 4'd6, "mid_2x3");
    step2(2'd3, 2'd3, 1'b1, 4'd0, "mid_rst_3x3");
    step2(2'd1, 2'd2, 1'b0, 4'd2, "mid_1x2");
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        step2(2'(x), 2'(y), 1'b0, 4'(x * y), $sformatf("exh_%0dx%0d", x, y));
      end
    end
    done2 = 1'b1;
  end

  // WIDTH=8 stimulus: extremes, then 1000 random pairs against A*B.
  initial begin
    logic [7:0] ra, rb;
    rst8 = 1'b1;
    a8 = 8'd0;
    b8 = 8'd0;
    step8(8'd255, 8'd255, 1'b1, 16'd0,     "w8_reset");
    step8(8'd255, 8'd255, 1'b0, 16'd65025, "w8_max");
    step8(8'd0,   8'd255, 1'b0, 16'd0,     "w8_zero");
    step8(8'd128, 8'd2,   1'b0, 16'd256,   "w8_128x2");
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      step8(ra, rb, 1'b0, 16'(ra) * 16'(rb), "w8_rand");
    end
    done8 = 1'b1;
  end

  // Monitor: P is valid every cycle, so pop one expectation per edge when one is pending.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q2.size() > 0) begin
        e = q2.pop_front();
        checks++;
        if (p2 !== e.p[3:0]) begin
          errors++;
          $display("FAIL %s: P=%0d expected %0d", e.tag, p2, e.p[3:0]);
        end
      end
      if (q8.size() > 0) begin
        e = q8.pop_front();
        checks++;
        if (p8 !== e.p) begin
          errors++;
          $display("FAIL %s: P=%0d expected %0d (A=%0d B=%0d)", e.tag, p8, e.p, a8, b8);
        end
      end
    end
  end

  // Finish once both streams are issued and drained, or on timeout.
  initial begin
    int cyc;
    cyc = 0;
    while (!(done2 && done8) && cyc < 5000) begin
      @(posedge clk);
      cyc++;
    end
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (!(done2 && done8) || q2.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: done2=%0d done8=%0d pending2=%0d pending8=%0d required all done and 0 pending",
               done2, done8, q2.size(), q8.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
